// File: rtl/codec_cfg_sequencer_if.sv
// codec_cfg_sequencer_if: table-load, run-control and word-generator handshake of the codec config sequencer.
interface codec_cfg_sequencer_if #(
   parameter int DATA_W       = 16,
   parameter int NUM_PROFILES = 4,
   parameter int DEPTH        = 8
);
   // one spare profile code so an out-of-range request is representable
   localparam int PW = $clog2(NUM_PROFILES + 1);
   localparam int AW = $clog2(NUM_PROFILES * DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   logic              tbl_we;
   logic [AW-1:0]     tbl_addr;
   logic [DATA_W-1:0] tbl_wdata;
   logic              start;
   logic [PW-1:0]     profile;
   logic              abort;
   logic [DATA_W-1:0] i2c_data;
   logic              i2c_load;
   logic              i2c_ready;
   logic              busy;
   logic              done;
   logic              error;
   logic [CW-1:0]     cmd_count;
   modport master (
      output tbl_we, tbl_addr, tbl_wdata, start, profile, abort, i2c_ready,
      input  i2c_data, i2c_load, busy, done, error, cmd_count
   );
   modport slave (
      input  tbl_we, tbl_addr, tbl_wdata, start, profile, abort, i2c_ready,
      output i2c_data, i2c_load, busy, done, error, cmd_count
   );
endinterface

// File: rtl/codec_cfg_sequencer.sv
// codec_cfg_sequencer: streams a runtime-loaded command list into the I2C word generator.
module codec_cfg_sequencer #(
   parameter int                DATA_W       = 16,
   parameter int                NUM_PROFILES = 4,
   parameter int                DEPTH        = 8,
   parameter logic [DATA_W-1:0] END_WORD     = 16'hFFFF,
   parameter int                GAP_CYCLES   = 64,
   parameter int                TIMEOUT      = 1000000
) (
   input logic                 clk,
   input logic                 reset_n,
   codec_cfg_sequencer_if.slave bus
);
   localparam int N  = NUM_PROFILES * DEPTH;
   localparam int PW = $clog2(NUM_PROFILES + 1);
   localparam int AW = $clog2(N);
   localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam int GW = GAP_CYCLES > 1 ? $clog2(GAP_CYCLES + 1) : 1;
   localparam int TW = TIMEOUT > 1 ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [2:0] CLEAR   = 3'd0;
   localparam logic [2:0] IDLE    = 3'd1;
   localparam logic [2:0] FETCH   = 3'd2;
   localparam logic [2:0] CHECK   = 3'd3;
   localparam logic [2:0] WAITRDY = 3'd4;
   localparam logic [2:0] GAP     = 3'd5;
   localparam logic [2:0] DRAIN   = 3'd6;
   localparam logic [2:0] DONE    = 3'd7;
   logic [2:0]        state;
   logic [AW-1:0]     clr_idx;
   logic [PW-1:0]     prof;
   logic [IW-1:0]     idx;
   logic [DATA_W-1:0] mem [N];
   logic [DATA_W-1:0] word;
   logic [DATA_W-1:0] data_q;
   logic [GW-1:0]     gap_cnt;
   logic [TW-1:0]     tmo_cnt;
   logic              err_q;
   logic              bad_q;
   logic [CW-1:0]     cnt_q;
   logic [AW-1:0]     rd_addr;
   logic              load;
   logic              last;
   logic              tmo_hit;
   assign rd_addr = AW'(prof * DEPTH + idx);
   // load is combinational so it can only coincide with ready, and dies with reset
   assign load    = reset_n && state == WAITRDY && bus.i2c_ready && !bus.abort;
   assign last    = idx == IW'(DEPTH - 1);
   assign tmo_hit = TIMEOUT != 0 && !bus.i2c_ready && tmo_cnt == TW'(TIMEOUT - 1);
   assign bus.i2c_load  = load;
   assign bus.i2c_data  = load ? word : data_q;
   assign bus.busy      = state != IDLE;
   assign bus.done      = state == DONE || bad_q;
   assign bus.error     = err_q;
   assign bus.cmd_count = cnt_q;
   // read-before-write: a same-cycle write to the fetched entry yields the old word
   always_ff @(posedge clk) begin
      if (state == CLEAR) mem[clr_idx] <= END_WORD;
      else if (bus.tbl_we && reset_n) mem[bus.tbl_addr] <= bus.tbl_wdata;
      if (state == FETCH) word <= mem[rd_addr];
   end
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state   <= CLEAR;
         clr_idx <= '0;
         prof    <= '0;
         idx     <= '0;
         data_q  <= '0;
         gap_cnt <= '0;
         tmo_cnt <= '0;
         err_q   <= 1'b0;
         bad_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         bad_q   <= 1'b0;
         tmo_cnt <= '0;
         if (load) begin
            data_q <= word;
            cnt_q  <= cnt_q + 1'b1;
         end
         case (state)
            CLEAR: begin
               clr_idx <= clr_idx + 1'b1;
               if (clr_idx == AW'(N - 1)) state <= IDLE;
            end
            IDLE: if (bus.start) begin
               if (bus.profile < PW'(NUM_PROFILES)) begin
                  prof  <= bus.profile;
                  idx   <= '0;
                  cnt_q <= '0;
                  err_q <= 1'b0;
                  state <= FETCH;
               end else begin
                  err_q <= 1'b1;
                  bad_q <= 1'b1;
               end
            end
            FETCH: state <= bus.abort ? DRAIN : CHECK;
            CHECK: state <= bus.abort || word == END_WORD ? DRAIN : WAITRDY;
            WAITRDY: begin
               if (bus.abort) state <= DRAIN;
               else if (bus.i2c_ready) begin
                  gap_cnt <= GW'(GAP_CYCLES);
                  if (GAP_CYCLES != 0) state <= GAP;
                  else if (last) state <= DRAIN;
                  else begin
                     idx   <= idx + 1'b1;
                     state <= FETCH;
                  end
               end else if (tmo_hit) begin
                  err_q <= 1'b1;
                  state <= DONE;
               end else tmo_cnt <= tmo_cnt + 1'b1;
            end
            GAP: begin
               if (bus.abort) state <= DRAIN;
               else if (gap_cnt > GW'(1)) gap_cnt <= gap_cnt - 1'b1;
               else if (last) state <= DRAIN;
               else begin
                  idx   <= idx + 1'b1;
                  state <= FETCH;
               end
            end
            DRAIN: begin
               if (bus.i2c_ready) state <= DONE;
               else if (tmo_hit) begin
                  err_q <= 1'b1;
                  state <= DONE;
               end else tmo_cnt <= tmo_cnt + 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_codec_cfg_sequencer.sv
// tb_codec_cfg_sequencer: directed runs against a load/done scoreboard.
module tb_codec_cfg_sequencer;
   localparam logic [15:0] END_W = 16'hFFFF;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;
   codec_cfg_sequencer_if #(.DATA_W(16), .NUM_PROFILES(4), .DEPTH(8)) bus ();
   codec_cfg_sequencer #(
      .DATA_W(16), .NUM_PROFILES(4), .DEPTH(8), .END_WORD(16'hFFFF),
      .GAP_CYCLES(64), .TIMEOUT(100)
   ) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
   logic [15:0] exp_load[$];
   logic [4:0]  exp_done[$];
   int          load_t[$];
   logic [4:0]  de;
   int cyc = 0;
   int checks = 0;
   int passes = 0;
   int dones_seen = 0;
   int done_time = 0;
   always @(posedge clk) cyc <= cyc + 1;
   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
   endfunction
   function automatic void fail(string msg);
      checks++;
      $display("FAIL %s (cycle %0d)", msg, cyc);
   endfunction
   // scoreboard monitor
   always @(negedge clk) begin
      if (bus.i2c_load) begin
         chk("load_needs_ready", 32'(bus.i2c_ready), 1);
         if (exp_load.size() == 0) fail($sformatf("unexpected_load data=%h", bus.i2c_data));
         else chk("load_data", 32'(bus.i2c_data), 32'(exp_load.pop_front()));
         load_t.push_back(cyc);
      end
      if (bus.done) begin
         if (exp_done.size() == 0) fail("unexpected_done");
         else begin
            de = exp_done.pop_front();
            chk("done_error", 32'(bus.error), 32'(de[4]));
            chk("done_count", 32'(bus.cmd_count), 32'(de[3:0]));
         end
         done_time = cyc;
         dones_seen++;
      end
   end
   task automatic step(int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask
   task automatic wr(int a, logic [15:0] d);
      bus.tbl_we = 1'b1;
      bus.tbl_addr = 5'(a);
      bus.tbl_wdata = d;
      step();
      bus.tbl_we = 1'b0;
   endtask
   task automatic run(int p);
      bus.start = 1'b1;
      bus.profile = 3'(p);
      step();
      bus.start = 1'b0;
   endtask
   task automatic wait_done(int d0, int limit);
      int n;
      n = 0;
      while (dones_seen == d0 && n < limit) begin
         step();
         n++;
      end
      if (dones_seen == d0) fail("wait_done_timeout");
   endtask
   task automatic wait_loads(int k, int limit);
      int n;
      n = 0;
      while (load_t.size() < k && n < limit) begin
         step();
         n++;
      end
      if (load_t.size() < k) fail("wait_loads_timeout");
   endtask
   task automatic release_and_sweep();
      int n;
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      n = 0;
      while (n < 100) begin
         @(negedge clk);
         if (!bus.busy) break;
         n++;
      end
      chk("clear_sweep_cycles", 32'(n), 32);
      step();
   endtask
   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end
   initial begin
      int d0, s;
      bus.tbl_we = 0; bus.tbl_addr = 0; bus.tbl_wdata = 0;
      bus.start = 0; bus.profile = 0; bus.abort = 0; bus.i2c_ready = 1;
      step(3);
      @(negedge clk);
      chk("rst_busy", 32'(bus.busy), 1);
      chk("rst_load", 32'(bus.i2c_load), 0);
      chk("rst_done", 32'(bus.done), 0);
      chk("rst_error", 32'(bus.error), 0);
      chk("rst_count", 32'(bus.cmd_count), 0);
      chk("rst_data", 32'(bus.i2c_data), 0);
      release_and_sweep();
      // empty profile
      exp_done.push_back({1'b0, 4'd0});
      d0 = dones_seen; run(2); wait_done(d0, 50);
      // two-word profile with terminator
      wr(8, 16'h0F00); wr(9, 16'h040A); wr(10, END_W);
      exp_load.push_back(16'h0F00); exp_load.push_back(16'h040A);
      exp_done.push_back({1'b0, 4'd2});
      load_t.delete();
      d0 = dones_seen; run(1); wait_done(d0, 1000);
      chk("p1_loads", 32'(load_t.size()), 2);
      if (load_t.size() == 2) chk("p1_spacing", 32'(load_t[1] - load_t[0]), 67);
      // full profile, ready low 20 cycles before load 4
      for (int i = 0; i < 8; i++) begin
         wr(24 + i, 16'h3000 + 16'(i));
         exp_load.push_back(16'h3000 + 16'(i));
      end
      exp_done.push_back({1'b0, 4'd8});
      load_t.delete();
      d0 = dones_seen; run(3);
      wait_loads(3, 1000);
      step(66);
      bus.i2c_ready = 0;
      step(20);
      bus.i2c_ready = 1;
      wait_done(d0, 2000);
      chk("p3_loads", 32'(load_t.size()), 8);
      if (load_t.size() == 8)
         for (int i = 1; i < 8; i++) chk($sformatf("p3_spacing_%0d", i), 32'(load_t[i] - load_t[i-1]), i == 3 ? 87 : 67);
      // ready timeout
      wr(0, 16'h0A01); wr(1, 16'h0A02); wr(2, END_W);
      exp_load.push_back(16'h0A01);
      exp_done.push_back({1'b1, 4'd1});
      load_t.delete();
      d0 = dones_seen; run(0);
      wait_loads(1, 200);
      bus.i2c_ready = 0;
      wait_done(d0, 400);
      if (load_t.size() == 1) chk("tmo_latency", 32'(done_time - load_t[0]), 167);
      @(negedge clk);
      chk("tmo_error_sticky", 32'(bus.error), 1);
      step();
      bus.i2c_ready = 1;
      exp_done.push_back({1'b0, 4'd0});
      d0 = dones_seen; run(2); wait_done(d0, 50);
      // abort in the gap after load 2 of 5, with an ignored start mid-run
      for (int i = 0; i < 5; i++) wr(i, 16'h0B01 + 16'(i));
      wr(5, END_W);
      exp_load.push_back(16'h0B01); exp_load.push_back(16'h0B02);
      exp_done.push_back({1'b0, 4'd2});
      load_t.delete();
      d0 = dones_seen; run(0);
      wait_loads(1, 200);
      run(3);
      wait_loads(2, 200);
      bus.abort = 1; bus.i2c_ready = 0;
      step();
      bus.abort = 0;
      step(9);
      bus.i2c_ready = 1;
      wait_done(d0, 100);
      if (load_t.size() == 2) chk("abort_done_latency", 32'(done_time - load_t[1]), 12);
      // out-of-range profile
      exp_done.push_back({1'b1, 4'd2});
      d0 = dones_seen;
      s = cyc;
      run(4);
      wait_done(d0, 10);
      chk("bad_profile_done_latency", 32'(done_time - s), 1);
      @(negedge clk);
      chk("bad_profile_idle", 32'(bus.busy), 0);
      step();
      // reset while waiting for ready
      bus.i2c_ready = 0;
      run(1);
      step(5);
      bus.i2c_ready = 1;
      reset_n = 0;
      @(negedge clk);
      chk("reset_load_same", 32'(bus.i2c_load), 0);
      @(negedge clk);
      chk("reset_load_next", 32'(bus.i2c_load), 0);
      chk("reset_busy", 32'(bus.busy), 1);
      release_and_sweep();
      for (int p = 0; p < 4; p++) begin
         exp_done.push_back({1'b0, 4'd0});
         d0 = dones_seen; run(p); wait_done(d0, 50);
      end
      chk("exp_load_drained", 32'(exp_load.size()), 0);
      chk("exp_done_drained", 32'(exp_done.size()), 0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
